// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage
//   ID/EX pipeline boundary register with valid/ready flow control, a
//   one-entry skid buffer and synchronous flush. in_ready is derived only
//   from internal state, so there is no combinational path from out_ready
//   or in_valid to any output.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               drop all held entries (redirect); main ctrl -> bubble
//   in_valid/in_ready   decode-side handshake
//   in_*                payload: ctrl, imm, pa, pb, pc, rs_addr, dest
//   out_valid/out_ready execute-side handshake
//   out_*               payload of the main slot (ctrl masked to bubble when
//                       out_valid is low)
//   occupancy           number of held entries (0..2)
module id_ex_skid_stage #(
    parameter int unsigned               CTRL_W      = 24,
    parameter int unsigned               IMM_W       = 16,
    parameter int unsigned               DATA_W      = 32,
    parameter int unsigned               DEST_W      = 5,
    parameter logic [CTRL_W-1:0]         BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_pa,
    input  logic [DATA_W-1:0] in_pb,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs_addr,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [IMM_W-1:0]  out_imm,
    output logic [DATA_W-1:0] out_pa,
    output logic [DATA_W-1:0] out_pb,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs_addr,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
);

    // Encoding is {main_v, skid_v}; {0,1} is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic main_v, skid_v;
    logic acc, fire;
    logic load_main_in, load_main_skid, load_skid_in;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [IMM_W-1:0]  main_imm,  skid_imm;
    logic [DATA_W-1:0] main_pa,   skid_pa;
    logic [DATA_W-1:0] main_pb,   skid_pb;
    logic [DATA_W-1:0] main_pc,   skid_pc;
    logic [DATA_W-1:0] main_rs,   skid_rs;
    logic [DEST_W-1:0] main_dest, skid_dest;

    assign main_v = state_q[1];
    assign skid_v = state_q[0];

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    assign acc  = in_valid & in_ready;
    assign fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        load_main_in = 1'b1;
                        state_d      = S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && fire) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        load_skid_in = 1'b1;
                        state_d      = S_FULL;
                    end else if (fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (fire) begin
                        load_main_skid = 1'b1;
                        state_d        = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl <= BUBBLE_CTRL;
            main_imm  <= '0;
            main_pa   <= '0;
            main_pb   <= '0;
            main_pc   <= '0;
            main_rs   <= '0;
            main_dest <= '0;
            skid_ctrl <= '0;
            skid_imm  <= '0;
            skid_pa   <= '0;
            skid_pb   <= '0;
            skid_pc   <= '0;
            skid_rs   <= '0;
            skid_dest <= '0;
        end else begin
            // Flush only bubbles the control word; data fields keep their value.
            if (flush) begin
                main_ctrl <= BUBBLE_CTRL;
            end else if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_imm  <= in_imm;
                main_pa   <= in_pa;
                main_pb   <= in_pb;
                main_pc   <= in_pc;
                main_rs   <= in_rs_addr;
                main_dest <= in_dest;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_imm  <= skid_imm;
                main_pa   <= skid_pa;
                main_pb   <= skid_pb;
                main_pc   <= skid_pc;
                main_rs   <= skid_rs;
                main_dest <= skid_dest;
            end
            if (load_skid_in) begin
                skid_ctrl <= in_ctrl;
                skid_imm  <= in_imm;
                skid_pa   <= in_pa;
                skid_pb   <= in_pb;
                skid_pc   <= in_pc;
                skid_rs   <= in_rs_addr;
                skid_dest <= in_dest;
            end
        end
    end

    assign out_ctrl    = main_v ? main_ctrl : BUBBLE_CTRL;
    assign out_imm     = main_imm;
    assign out_pa      = main_pa;
    assign out_pb      = main_pb;
    assign out_pc      = main_pc;
    assign out_rs_addr = main_rs;
    assign out_dest    = main_dest;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage
//   Drives id_ex_skid_stage with directed scenarios and randomized traffic.
//   A queue-based model (at most two entries, FIFO order) predicts every
//   output after each clock edge.
module tb_id_ex_skid_stage;

    localparam logic [23:0] BUBBLE = 24'hA5_0F00;

    typedef struct packed {
        logic [23:0] ctrl;
        logic [15:0] imm;
        logic [31:0] pa;
        logic [31:0] pb;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [4:0]  dest;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, out_ready;
    ent_t       in_e;
    ent_t       out_e;
    logic       in_ready, out_valid;
    logic [1:0] occupancy;

    always #5 clk = ~clk;

    id_ex_skid_stage #(
        .CTRL_W(24), .IMM_W(16), .DATA_W(32), .DEST_W(5), .BUBBLE_CTRL(BUBBLE)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_e.ctrl), .in_imm(in_e.imm), .in_pa(in_e.pa), .in_pb(in_e.pb),
        .in_pc(in_e.pc), .in_rs_addr(in_e.rs), .in_dest(in_e.dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_e.ctrl), .out_imm(out_e.imm), .out_pa(out_e.pa), .out_pb(out_e.pb),
        .out_pc(out_e.pc), .out_rs_addr(out_e.rs), .out_dest(out_e.dest),
        .occupancy(occupancy)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned delivered = 0;

    ent_t q[$];
    ent_t last_head;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic ent_t rnd_ent(input logic [31:0] pc);
        ent_t e;
        e.ctrl = 24'($urandom);
        e.imm  = 16'($urandom);
        e.pa   = $urandom;
        e.pb   = $urandom;
        e.pc   = pc;
        e.rs   = $urandom;
        e.dest = 5'($urandom);
        return e;
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare all DUT outputs 1 time unit later.
    task automatic tick();
        bit   m_in_ready, m_out_valid, acc, fire;
        ent_t exp_e;
        @(posedge clk);
        m_in_ready  = (q.size() < 2);
        m_out_valid = (q.size() > 0);
        acc  = in_valid && m_in_ready;
        fire = m_out_valid && out_ready;
        if (reset) begin
            q.delete();
            last_head = '0;
        end else if (flush) begin
            if (fire) delivered++;
            q.delete();
        end else begin
            if (fire) begin
                void'(q.pop_front());
                delivered++;
            end
            if (acc) q.push_back(in_e);
        end
        if (q.size() > 0) last_head = q[0];
        #1;
        exp_e      = last_head;
        exp_e.ctrl = (q.size() > 0) ? q[0].ctrl : BUBBLE;
        chk("out_valid", 200'(out_valid), 200'(q.size() > 0));
        chk("in_ready",  200'(in_ready),  200'(q.size() < 2));
        chk("occupancy", 200'(occupancy), 200'(q.size()));
        chk("payload",   200'(out_e),     200'(exp_e));
    endtask

    task automatic drive(input bit v, input bit r, input logic [31:0] pc);
        in_valid  = v;
        out_ready = r;
        in_e      = rnd_ent(pc);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        drive(1'b1, 1'b0, 32'h99);

        // Reset held two cycles with in_valid high
        tick();
        tick();
        chk("rst_valid", 200'(out_valid), 200'(0));
        chk("rst_ready", 200'(in_ready), 200'(1));
        chk("rst_occ",   200'(occupancy), 200'(0));
        chk("rst_ctrl",  200'(out_e.ctrl), 200'(BUBBLE));
        chk("rst_pc",    200'(out_e.pc), 200'(0));
        reset = 1'b0;

        // Streaming
        drive(1'b1, 1'b1, 32'h00); tick();
        chk("str_pc0", 200'(out_e.pc), 200'(32'h00));
        chk("str_rdy0", 200'(in_ready), 200'(1));
        drive(1'b1, 1'b1, 32'h04); tick();
        chk("str_pc4", 200'(out_e.pc), 200'(32'h04));
        drive(1'b1, 1'b1, 32'h08); tick();
        chk("str_pc8", 200'(out_e.pc), 200'(32'h08));
        chk("str_rdy8", 200'(in_ready), 200'(1));
        drive(1'b0, 1'b1, 32'h0); tick();
        chk("str_drain", 200'(out_valid), 200'(0));

        // Stall / skid
        drive(1'b1, 1'b0, 32'h10); tick();
        drive(1'b1, 1'b0, 32'h14); tick();
        chk("stl_occ", 200'(occupancy), 200'(2));
        chk("stl_rdy", 200'(in_ready), 200'(0));
        chk("stl_pc",  200'(out_e.pc), 200'(32'h10));
        drive(1'b1, 1'b0, 32'h18); tick();
        chk("stl_hold", 200'(out_e.pc), 200'(32'h10));
        drive(1'b0, 1'b1, 32'h0); tick();
        chk("stl_pc14", 200'(out_e.pc), 200'(32'h14));
        chk("stl_rdy1", 200'(in_ready), 200'(1));
        tick();
        chk("stl_empty", 200'(occupancy), 200'(0));

        // Flush while FULL, with a concurrent offer that must be dropped
        drive(1'b1, 1'b0, 32'h20); tick();
        drive(1'b1, 1'b0, 32'h24); tick();
        chk("fl_full", 200'(occupancy), 200'(2));
        flush = 1'b1;
        drive(1'b1, 1'b0, 32'h28); tick();
        flush = 1'b0;
        chk("fl_valid", 200'(out_valid), 200'(0));
        chk("fl_occ",   200'(occupancy), 200'(0));
        chk("fl_ctrl",  200'(out_e.ctrl), 200'(BUBBLE));
        drive(1'b0, 1'b1, 32'h0); tick();
        chk("fl_drop", 200'(out_valid), 200'(0));

        // Accept + fire together in ONE
        drive(1'b1, 1'b0, 32'h30); tick();
        chk("one_pc30", 200'(out_e.pc), 200'(32'h30));
        drive(1'b1, 1'b1, 32'h34); tick();
        chk("one_pc34", 200'(out_e.pc), 200'(32'h34));
        chk("one_occ",  200'(occupancy), 200'(1));
        drive(1'b0, 1'b1, 32'h0); tick();

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(99) < 70, $urandom_range(99) < 55, 32'h1000 + 32'(i) * 4);
            flush = ($urandom_range(999) < 15);
            reset = ($urandom_range(999) < 3);
            tick();
        end
        reset = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b1, 32'h0);
        tick();
        tick();
        chk("end_empty", 200'(occupancy), 200'(0));
        chk("delivered", 200'(delivered > 2000), 200'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
